// File: rtl/axil_pkg.sv
// Shared AXI-lite response codes and register-bank address decode.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic       hit_rw;
    logic       hit_status;
    logic [7:0] idx;
  } dec_t;

  // Word index relative to base; addresses below base never hit.
  function automatic dec_t decode(input logic [63:0] addr, input logic [63:0] base,
                                  input int unsigned num_regs);
    dec_t        d;
    logic [63:0] word;
    d    = '0;
    word = (addr - base) >> 2;
    if (addr >= base) begin
      d.hit_rw     = word < 64'(num_regs);
      d.hit_status = word == 64'(num_regs);
      d.idx        = 8'(word);
    end
    return d;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI-lite bus bundle between an AXI-lite master and the register bank.
interface axil_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_bank.sv
// AXI-lite register bank: NUM_REGS RW words plus a read-only status word, flat reg_out.
// Write commits the cycle after both AW and W are held and B is free; read latency 1, held until rready.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axil_reg_bank_if.slave                 s_axil,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  logic                           aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d;
  logic                           w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]          wstrb_q, wstrb_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic                           rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

  logic commit;
  dec_t wr_dec, rd_dec;
  logic unused_prot;

  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};
  assign commit      = aw_held_q && w_held_q && !bvalid_q;
  assign wr_dec      = decode(64'(awaddr_q), 64'(BASE_ADDR), NUM_REGS);
  assign rd_dec      = decode(64'(s_axil.araddr), 64'(BASE_ADDR), NUM_REGS);

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    if (s_axil.awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil.awaddr;
    end
    if (s_axil.wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil.wdata;
      wstrb_d  = s_axil.wstrb;
    end
    if (bvalid_q && s_axil.bready) bvalid_d = 1'b0;

    // Holding flags are both set here, so no new AW/W can be accepted on this edge.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_dec.hit_rw ? RESP_OKAY : RESP_SLVERR;
      if (wr_dec.hit_rw) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wstrb_q[b]) regs_d[int'(wr_dec.idx)*DATA_WIDTH + 8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end

    if (rvalid_q && s_axil.rready) rvalid_d = 1'b0;
    // Reads sample regs_q, so a commit on the same edge is not yet visible.
    if (s_axil.arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      if (rd_dec.hit_rw) begin
        rdata_d = regs_q[int'(rd_dec.idx)*DATA_WIDTH +: DATA_WIDTH];
        rresp_d = RESP_OKAY;
      end else if (rd_dec.hit_status) begin
        rdata_d = status_in;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= {NUM_REGS{RESET_VAL}};
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axil.awready = !aw_held_q;
  assign s_axil.wready  = !w_held_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = !rvalid_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign reg_out        = regs_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Scoreboard bench for axil_reg_bank: directed writes/reads queue expected B/R responses, a monitor checks them.
module tb_axil_reg_bank;

  localparam int         NREGS  = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic                  clk;
  logic                  rst;
  logic [31:0]           status_in;
  logic [NREGS*32-1:0]   reg_out;

  logic [1:0]  b_exp_q[$];
  rexp_t       r_exp_q[$];
  logic [31:0] exp_regs[NREGS];
  int          n_tests;
  int          n_fail;

  axil_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifc ();

  axil_reg_bank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .NUM_REGS(NREGS),
    .BASE_ADDR(32'h0), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .s_axil(ifc), .status_in(status_in), .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    int bad;
    bad = -1;
    for (int i = NREGS - 1; i >= 0; i--)
      if (reg_out[32*i +: 32] !== exp_regs[i]) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: reg %0d got %h expected %h", name, bad, reg_out[32*bad +: 32], exp_regs[bad]);
    end
  endtask

  // Scoreboard monitor: a handshake is seen exactly once, at the negedge before its edge.
  always @(negedge clk) begin
    if (rst) begin
      if (ifc.bvalid && ifc.bready) begin
        if (b_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got bresp %b expected no response", ifc.bresp);
        end else begin
          chk("bresp", 64'(ifc.bresp), 64'(b_exp_q.pop_front()));
        end
      end
      if (ifc.rvalid && ifc.rready) begin
        if (r_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got rdata %h expected no response", ifc.rdata);
        end else begin
          rexp_t e;
          e = r_exp_q.pop_front();
          chk("rresp_rdata", {30'd0, ifc.rresp, ifc.rdata}, {30'd0, e.r, e.d});
        end
      end
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", name, b_exp_q.size() + r_exp_q.size());
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input bit wait_b);
    bit aw_done, w_done, aw_hs, w_hs;
    int t, idx;
    b_exp_q.push_back(resp);
    idx = int'(addr >> 2);
    if (resp == OKAY && idx < NREGS)
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_regs[idx][8*b +: 8] = data[8*b +: 8];
    @(posedge clk); #1;
    ifc.awaddr = addr; ifc.awvalid = 1'b1;
    ifc.wdata = data; ifc.wstrb = strb; ifc.wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      aw_hs = ifc.awvalid && ifc.awready;
      w_hs  = ifc.wvalid && ifc.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1'b1; ifc.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1'b1;  ifc.wvalid = 1'b0;  end
      t++;
    end
    if (t >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL write_hs_timeout: got no AW/W handshake expected one for addr %h", addr);
      ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    end
    if (wait_b) drain("write_b");
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    rexp_t e;
    bit hs;
    int t;
    e.d = data; e.r = resp;
    r_exp_q.push_back(e);
    @(posedge clk); #1;
    ifc.araddr = addr; ifc.arvalid = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      hs = ifc.arready;
      @(posedge clk); #1;
      t++;
    end
    ifc.arvalid = 1'b0;
    chk("r_latency1", 64'(ifc.rvalid), 64'd1);
    drain("read_r");
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
    rst = 1'b0; status_in = 32'h0;
    ifc.awaddr = '0; ifc.awprot = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wvalid = 1'b0; ifc.bready = 1'b1;
    ifc.araddr = '0; ifc.arprot = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_bvalid", 64'(ifc.bvalid), 64'd0);
    chk("rst_rvalid", 64'(ifc.rvalid), 64'd0);
    chk("rst_ready", {62'd0, ifc.awready, ifc.wready}, 64'd3);
    chk("rst_resp_rdata", {28'd0, ifc.bresp, ifc.rresp, ifc.rdata}, 64'd0);
    check_regs("rst_regs");

    // Reset lands between the AW/W handshake and the commit edge.
    @(posedge clk); #1;
    ifc.awaddr = 32'hC; ifc.awvalid = 1'b1;
    ifc.wdata = 32'h55AA55AA; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    @(posedge clk); #1;
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_bvalid", 64'(ifc.bvalid), 64'd0);
    chk("midrst_awready", 64'(ifc.awready), 64'd1);
    check_regs("midrst_no_commit");

    // AW handshake, W three cycles later, commit one cycle after W.
    b_exp_q.push_back(OKAY);
    exp_regs[2] = 32'hA5A51234;
    @(posedge clk); #1;
    ifc.awaddr = 32'h8; ifc.awvalid = 1'b1;
    @(posedge clk); #1;
    ifc.awvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 ifc.wdata = 32'hA5A51234; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    @(negedge clk);
    chk("b_before_w", 64'(ifc.bvalid), 64'd0);
    @(posedge clk); #1;
    ifc.wvalid = 1'b0;
    @(negedge clk);
    chk("b_not_early", 64'(ifc.bvalid), 64'd0);
    @(negedge clk);
    chk("b_after_commit", 64'(ifc.bvalid), 64'd1);
    chk("reg2", 64'(reg_out[64 +: 32]), 64'hA5A51234);
    drain("t2");

    // Partial strobe, then a zero-strobe write that must leave the register intact.
    do_write(32'h14, 32'hFFFFFFFF, 4'b0101, OKAY, 1'b1);
    chk("reg5_strb", 64'(reg_out[160 +: 32]), 64'h00FF00FF);
    do_read(32'h14, 32'h00FF00FF, OKAY);
    do_write(32'h14, 32'h12345678, 4'h0, OKAY, 1'b1);
    check_regs("wstrb0");

    // Last register, with ignored low address bits on the read.
    do_write(32'h3C, 32'hDEADBEEF, 4'hF, OKAY, 1'b1);
    do_read(32'h3F, 32'hDEADBEEF, OKAY);

    // Status word.
    status_in = 32'h12345678;
    do_read(32'h40, 32'h12345678, OKAY);
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, SLVERR, 1'b1);
    check_regs("status_write_dropped");

    // Out of range and B backpressure.
    do_read(32'h1000, 32'h0, SLVERR);
    do_write(32'h44, 32'hFFFFFFFF, 4'hF, SLVERR, 1'b1);
    @(posedge clk); #1 ifc.bready = 1'b0;
    do_write(32'h18, 32'h11111111, 4'hF, OKAY, 1'b0);
    do_write(32'h18, 32'h22222222, 4'hF, OKAY, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("b_held", 64'(ifc.bvalid), 64'd1);
    end
    chk("second_waits", 64'(reg_out[192 +: 32]), 64'h11111111);
    chk("aw_held_while_b", 64'(ifc.awready), 64'd0);
    @(posedge clk); #1 ifc.bready = 1'b1;
    drain("t5");
    @(negedge clk);
    chk("second_commits", 64'(reg_out[192 +: 32]), 64'h22222222);
    check_regs("t5_regs");

    // Same-edge commit and read of reg 1.
    do_write(32'h4, 32'h00001111, 4'hF, OKAY, 1'b1);
    begin
      rexp_t e;
      e.d = 32'h00001111; e.r = OKAY;
      r_exp_q.push_back(e);
    end
    b_exp_q.push_back(OKAY);
    exp_regs[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    ifc.awaddr = 32'h4; ifc.awvalid = 1'b1;
    ifc.wdata = 32'hCAFEF00D; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    @(posedge clk); #1;
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    ifc.araddr = 32'h4; ifc.arvalid = 1'b1;
    @(posedge clk); #1;
    ifc.arvalid = 1'b0;
    drain("t6");
    do_read(32'h4, 32'hCAFEF00D, OKAY);
    check_regs("final_regs");

    repeat (5) @(posedge clk);
    chk("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
    chk("r_queue_empty", 64'(r_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
